// File: rtl/transpose_ctrl.sv
// Row-major to column-major matrix transpose controller.
// Fills an external 2-cycle-latency BRAM, then drains it column by column through a 4-entry FIFO.
module transpose_ctrl #(
  parameter int DATAW = 8,
  parameter int N     = 4,
  parameter int DEPTH = N * N,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] mem_wdata,
  output logic [ADDRW-1:0] mem_waddr,
  output logic             mem_wen,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             frame_done
);

  localparam int CNTW       = $clog2(DEPTH + 1);
  localparam int RCW        = (N > 1) ? $clog2(N) : 1;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDRW-1:0] raddr_q, raddr_d;
  logic [RCW-1:0]   rd_r_q, rd_r_d, rd_c_q, rd_c_d;
  logic [CNTW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNTW-1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]       vld_q, vld_d;
  logic [DATAW-1:0] fifo_q [FIFO_DEPTH];
  logic [DATAW-1:0] fifo_d [FIFO_DEPTH];
  logic [1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]       count_q, count_d;

  logic             in_hs, issue, push, pop, last_pop;
  logic [2:0]       credit;
  logic [ADDRW-1:0] rd_addr;

  // Credit covers both buffered and in-flight elements so the FIFO can never overflow.
  assign credit   = count_q + {2'b0, vld_q[0]} + {2'b0, vld_q[1]};
  assign in_hs    = rst_n && (state_q == FILL) && in_valid;
  assign issue    = (state_q == DRAIN) && (rd_cnt_q < CNTW'(DEPTH)) && (credit < 3'd4);
  assign rd_addr  = ADDRW'(int'(rd_r_q) * N + int'(rd_c_q));
  assign push     = vld_q[1];
  assign pop      = (count_q != 3'd0) && out_ready;
  assign last_pop = pop && (out_cnt_q == CNTW'(DEPTH - 1));

  assign in_ready   = (state_q == FILL);
  assign mem_wen    = in_hs;
  assign mem_wdata  = in_data;
  assign mem_waddr  = wr_cnt_q;
  assign mem_raddr  = issue ? rd_addr : raddr_q;
  assign out_valid  = (count_q != 3'd0);
  assign out_data   = fifo_q[rptr_q];
  assign frame_done = last_pop;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    raddr_d   = raddr_q;
    rd_r_d    = rd_r_q;
    rd_c_d    = rd_c_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    vld_d     = {vld_q[0], issue};
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q + {2'b0, push} - {2'b0, pop};

    if (in_hs) begin
      if (wr_cnt_q == ADDRW'(DEPTH - 1)) begin
        wr_cnt_d = '0;
        state_d  = DRAIN;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDRW'(1);
      end
    end

    // Column-major walk: row index is the inner loop.
    if (issue) begin
      raddr_d  = rd_addr;
      rd_cnt_d = rd_cnt_q + CNTW'(1);
      if (rd_r_q == RCW'(N - 1)) begin
        rd_r_d = '0;
        rd_c_d = rd_c_q + RCW'(1);
      end else begin
        rd_r_d = rd_r_q + RCW'(1);
      end
    end

    if (push) begin
      fifo_d[wptr_q] = mem_rdata;
      wptr_d         = wptr_q + 2'd1;
    end

    if (pop) begin
      rptr_d    = rptr_q + 2'd1;
      out_cnt_d = out_cnt_q + CNTW'(1);
    end

    if (last_pop) begin
      state_d   = FILL;
      rd_r_d    = '0;
      rd_c_d    = '0;
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      raddr_q   <= '0;
      rd_r_q    <= '0;
      rd_c_q    <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      raddr_q   <= raddr_d;
      rd_r_q    <= rd_r_d;
      rd_c_q    <= rd_c_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule

// File: tb/tb_transpose_ctrl.sv
// Scoreboard bench for transpose_ctrl with a behavioural 2-cycle BRAM.
// Stimulus pushes the expected transposed stream; a negedge monitor pops and compares.
module tb_transpose_ctrl;

  localparam int DATAW = 8;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int ADDRW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] mem_wdata;
  logic [ADDRW-1:0] mem_waddr;
  logic             mem_wen;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic             frame_done;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   pops = 0;
  int   done_seen = 0;
  bit   rand_ready = 1'b0;

  logic [DATAW-1:0] bram [DEPTH];
  logic [DATAW-1:0] rd_p1, rd_p2;

  always #5 clk = ~clk;

  transpose_ctrl #(.DATAW(DATAW), .N(N), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .frame_done(frame_done)
  );

  // BRAM model: contents survive reset, read data appears two cycles after the address.
  always @(posedge clk) begin
    if (mem_wen) bram[mem_waddr] <= mem_wdata;
    rd_p1 <= bram[mem_raddr];
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out", int'(out_data), -1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_data", int'(out_data), mon_e.data);
          checkOutput("frame_done", int'(frame_done), int'(mon_e.last));
          if (frame_done) done_seen++;
        end
        pops++;
      end else begin
        checkOutput("frame_done_idle", int'(frame_done), 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(1));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds one frame base..base+15; waits whenever the DUT is not ready.
  task automatic applyStimulus(input int base, input int gap_pct, output int stall_cycles);
    int  i = 0;
    int  guard = 0;
    bit  hs;
    exp_t e;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) begin
        e.data = (base + r * N + c) & 255;
        e.last = (c == N - 1) && (r == N - 1);
        exp_q.push_back(e);
      end
    end
    stall_cycles = 0;
    while (i < DEPTH && guard < 2000) begin
      guard++;
      in_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      in_data  = DATAW'(base + i);
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs) begin
        checkOutput("mem_wen", int'(mem_wen), 1);
        checkOutput("mem_waddr", int'(mem_waddr), i);
        checkOutput("mem_wdata", int'(mem_wdata), (base + i) & 255);
      end else begin
        checkOutput("mem_wen_idle", int'(mem_wen), 0);
        if (in_valid) stall_cycles++;
      end
      step();
      if (hs) i++;
    end
    if (i < DEPTH) checkOutput("fill_timeout", i, DEPTH);
    in_valid = 1'b0;
  endtask

  // Counts negedges from D0 to the first out_valid and to frame_done.
  task automatic measureDrain(output int first, output int done);
    int n = 0;
    first = -1;
    done  = -1;
    while (done < 0 && n < 300) begin
      @(negedge clk);
      if (first < 0 && out_valid) first = n;
      if (frame_done) done = n;
      if (done < 0) begin
        step();
        n++;
      end
    end
  endtask

  int stall, stall2, first, done, n, start_pops, d0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_mem_wen", int'(mem_wen), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_mem_waddr", int'(mem_waddr), 0);
    checkOutput("rst_mem_raddr", int'(mem_raddr), 0);
    step();
    rst_n = 1'b1;

    $display("[TB] basic frame");
    applyStimulus(0, 0, stall);
    checkOutput("basic_fill_stall", stall, 0);
    measureDrain(first, done);
    checkOutput("basic_first_valid", first, 3);
    checkOutput("basic_done_cycle", done, 18);
    step();

    $display("[TB] output stall");
    out_ready = 1'b0;
    applyStimulus(16, 0, stall);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      step();
      n++;
      @(negedge clk);
    end
    checkOutput("stall_first_valid", n, 3);
    repeat (10) step();
    @(negedge clk);
    checkOutput("stall_raddr_held", int'(mem_raddr), 12);
    checkOutput("stall_out_valid", int'(out_valid), 1);
    step();
    out_ready = 1'b1;
    measureDrain(first, done);
    checkOutput("stall_release_done", done, 15);
    step();

    $display("[TB] input gaps");
    applyStimulus(32, 40, stall);
    checkOutput("gap_fill_stall", stall, 0);
    measureDrain(first, done);
    checkOutput("gap_first_valid", first, 3);
    checkOutput("gap_done_cycle", done, 18);
    step();

    $display("[TB] reset mid-drain");
    applyStimulus(48, 0, stall);
    start_pops = pops;
    n = 0;
    while (pops < start_pops + 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rst_wait_pops", pops - start_pops, 5);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    checkOutput("midrst_mem_raddr", int'(mem_raddr), 0);
    step();
    rst_n = 1'b1;
    applyStimulus(100, 0, stall);
    checkOutput("postrst_fill_stall", stall, 0);
    measureDrain(first, done);
    checkOutput("postrst_first_valid", first, 3);
    checkOutput("postrst_done_cycle", done, 18);
    step();

    $display("[TB] back-to-back frames");
    d0 = done_seen;
    applyStimulus(200, 0, stall);
    applyStimulus(60, 0, stall2);
    checkOutput("b2b_drain_wait", stall2, 19);
    measureDrain(first, done);
    checkOutput("b2b_first_valid", first, 3);
    checkOutput("b2b_done_cycle", done, 18);
    step();
    checkOutput("b2b_done_pulses", done_seen - d0, 2);

    $display("[TB] random out_ready, 20 frames");
    d0 = done_seen;
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) applyStimulus((f * 13) % 240, 30, stall);
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step();
      n++;
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    step();
    checkOutput("rand_queue_left", exp_q.size(), 0);
    checkOutput("rand_done_pulses", done_seen - d0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_ctrl.md
TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

Interface
REQ-001 SHALL have parameter DATAW, default 8, element width in bits.
REQ-002 SHALL have parameter N, default 4, matrix dimension (N x N elements per frame).
REQ-003 SHALL have parameter DEPTH, default N*N, buffer depth in elements; ADDRW, default $clog2(DEPTH), address width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports in_data  input  DATAW; in_valid  input  1; in_ready  output  1: row-major element input stream.
REQ-007 SHALL have ports out_data  output  DATAW; out_valid  output  1; out_ready  input  1: column-major element output stream.
REQ-008 SHALL have ports mem_wdata  output  DATAW; mem_waddr  output  ADDRW; mem_wen  output  1; mem_raddr  output  ADDRW: drive the downstream 2-cycle-latency BRAM buffer.
REQ-009 SHALL have port mem_rdata  input  DATAW  BRAM read data, valid 2 cycles after the address is presented.
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse on the last output handshake of a frame.

Function
REQ-011 SHALL implement states FILL and DRAIN; FILL after reset.
REQ-012 In FILL, in_ready SHALL be 1; an input handshake is in_valid && in_ready.
REQ-013 Each input handshake SHALL assert mem_wen combinationally, with mem_wdata = in_data and mem_waddr = wr_cnt, the element index 0..DEPTH-1 in arrival order (element (r,c) at r*N+c).
REQ-014 mem_wen SHALL be 0 in every cycle without an input handshake; input gaps SHALL not advance wr_cnt.
REQ-015 On the handshake with wr_cnt = DEPTH-1, the block SHALL clear wr_cnt and move to DRAIN in the next cycle.
REQ-016 In DRAIN, in_ready SHALL be 0 and mem_wen SHALL be 0.
REQ-017 In DRAIN, read issue order SHALL be column-major: outer c = 0..N-1, inner r = 0..N-1, mem_raddr = r*N + c.
REQ-018 A read SHALL issue in a cycle only if reads remain and fifo_occupancy + inflight < 4; mem_raddr holds its last value when no read issues.
REQ-019 A 2-stage valid shift register SHALL track issued reads; when stage 2 is set, mem_rdata SHALL be pushed into a 4-entry output FIFO at that clock edge.
REQ-020 out_valid SHALL equal FIFO not empty; out_data SHALL be the FIFO head; a pop occurs on out_valid && out_ready.
REQ-021 Pushes and pops in the same cycle SHALL both take effect; the credit rule SHALL guarantee the FIFO never overflows.
REQ-022 The first read SHALL issue in the first DRAIN cycle (D0); the first out_valid SHALL be in D0+3; with out_ready held 1, one element SHALL be output per cycle with no bubbles.
REQ-023 After the DEPTH-th output handshake, frame_done SHALL pulse for 1 cycle, all counters SHALL be 0, and the state SHALL return to FILL in the next cycle.
REQ-024 With out_ready low, issue SHALL stall once 4 elements are held or in flight; no element SHALL be lost, duplicated or reordered.
REQ-025 The first read of a frame SHALL observe the frame's last write; this SHALL be met by the 1-cycle FILL-to-DRAIN transition without an extra stall.

Reset
REQ-026 While rst_n = 0: state = FILL, all counters = 0, FIFO empty, shift register cleared, in_ready = 1, out_valid = 0, mem_wen = 0, frame_done = 0, mem_waddr = mem_raddr = 0.
REQ-027 Reset in mid-frame SHALL abandon the frame; in-flight BRAM reads SHALL be discarded, and BRAM contents are not cleared.

Verification
REQ-028 N=4, inputs 0..15 contiguous, out_ready=1 -> outputs 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_valid first in D0+3; frame_done with output 15.
REQ-029 Same frame, out_ready low for 10 cycles after the first out_valid -> at most 4 reads issued; the full sequence is correct after release.
REQ-030 Random in_valid gaps during fill -> mem_waddr 0..15 in order, mem_wen only on handshakes; output order as in REQ-028.
REQ-031 rst_n pulsed low in DRAIN after 5 outputs -> out_valid 0 and in_ready 1 immediately; a fresh frame 100..115 outputs 100,104,108,112,101,... with no stale data.
REQ-032 Two back-to-back frames with in_valid held 1 -> in_ready 0 during drain of frame 1; frame 2 is correct; frame_done pulses exactly twice.
REQ-033 Random out_ready (50%) over 20 frames -> scoreboard matches the transpose; FIFO occupancy never exceeds 4.
